// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// bus widths, default depth, the request record and the byte-lane merge.
package mem_pkg;

  localparam int WORD_W           = 32;
  localparam int BE_W             = 4;
  localparam int DM_DEPTH_DEFAULT = 3072;

  // Responder FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // One latched load/store request
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] pc;
  } req_t;

  // Replace the byte lanes of old_word selected by be with those of new_data
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_word,
                                                 input logic [WORD_W-1:0] new_data,
                                                 input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] w;
    w = old_word;
    for (int l = 0; l < BE_W; l++)
      if (be[l]) w[8*l +: 8] = new_data[8*l +: 8];
    return w;
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word-organised data RAM with per-byte-lane write enables, synchronous
// write, synchronous clear on reset and combinational read.
module dm_byte_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEFAULT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WORD_W-1:0] mem [DEPTH];

  // Lane-masked write; reset wipes every word
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared on reset because the load/store
      // contract promises zeroed memory after reset; this forbids RAM-macro
      // inference and builds the storage from flops.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int l = 0; l < BE_W; l++)
        if (be[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  // Index codes past DEPTH (possible when DEPTH is not a power of two) read 0
  assign rdata = ({1'b0, addr} < DEPTH_C) ? mem[addr] : '0;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one word-aligned load/store
// through a valid/ready handshake, performs it LATENCY cycles later and
// returns the result through a second valid/ready handshake.
// Optional build macro DM_TRACE_EN prints committed stores and errors.
module dm_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DM_DEPTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [WORD_W-1:0] req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [1:0]        state;
  logic [3:0]        cnt;
  req_t              req_in, req_q, acc;
  logic              enter_resp, acc_err, ram_we;
  logic [WORD_W-1:0] ram_rdata, new_word;

  assign req_in     = '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata, pc: req_pc};
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Pick the request being committed and decide whether this edge enters RESP
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    acc        = req_q;
    enter_resp = 1'b0;
    if (LATENCY == 1) begin
      // Single-cycle latency commits on the acceptance edge, before the
      // latch holds the request, so the live inputs are used.
      if (state == IDLE) acc = req_in;
      enter_resp = (state == IDLE) && req_valid;
    end else begin
      enter_resp = (state == WAIT) && (cnt == 4'd1);
    end
    acc_err  = (acc.addr[1:0] != 2'b00) || (acc.addr[31:2] >= DEPTH_W);
    ram_we   = enter_resp && acc.we && !acc_err;
    new_word = be_merge(ram_rdata, acc.wdata, acc.be);
  end

  dm_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .be    (acc.be),
    .addr  (acc.addr[AW+1:2]),
    .wdata (acc.wdata),
    .rdata (ram_rdata)
  );

  // FSM, latency counter, request latch and response registers
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q <= req_in;
          if (LATENCY == 1) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= acc_err ? '0 : (acc.we ? new_word : ram_rdata);
      end
    end
  end

`ifdef DM_TRACE_EN
  // Trace committed stores and errored requests
  always @(posedge clk) begin
    if (!reset && enter_resp) begin
      if (acc_err)     $display("@%08h: DM error %08h", acc.pc, acc.addr);
      else if (acc.we) $display("@%08h: *%08h <= %08h", acc.pc, acc.addr, new_word);
    end
  end
`else
  // The pc only feeds the trace
  logic unused_pc;
  assign unused_pc = ^acc.pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances (LATENCY 2, 1, 15)
// share the request bus; one is driven at a time. Stimulus pushes the
// expected response, per-instance monitors check latency, issue spacing
// and response contents.
module tb_dm_responder;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rv = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;
  logic        rr = 1'b1;
  logic [2:0]  rdy, vld, errs;
  logic [31:0] rdata [3];

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  bit   b2b = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    int   last_acc = -1;
    int   a;
    exp_t e;
    logic prev_v = 1'b0;

    dm_responder #(.DEPTH(3072), .LATENCY(L)) dut (
      .clk(clk), .reset(reset), .req_valid(rv[g]), .req_ready(rdy[g]),
      .req_we(we), .req_be(be), .req_addr(addr), .req_wdata(wdata), .req_pc(pc),
      .resp_valid(vld[g]), .resp_ready(rr), .resp_rdata(rdata[g]), .resp_err(errs[g])
    );

    // Monitor: acceptances, latency at each rise, contents at each consume
    always @(negedge clk) begin
      if (reset) begin
        prev_v   = 1'b0;
        last_acc = -1;
      end else begin
        if (!b2b) last_acc = -1;
        if (rv[g] && rdy[g]) begin
          acc_q.push_back(cyc + 1);
          if (last_acc >= 0) check($sformatf("issue_gap_L%0d", L), cyc + 1 - last_acc, L + 1);
          last_acc = cyc + 1;
        end
        if (vld[g] && !prev_v) begin
          if (acc_q.size() == 0) fail($sformatf("latency_noaccept_L%0d", L));
          else begin
            a = acc_q.pop_front();
            check($sformatf("latency_L%0d", L), cyc + 1 - a, L);
          end
        end
        if (vld[g] && rr) begin
          if (exp_q.size() == 0) fail($sformatf("unexpected_resp_L%0d", L));
          else begin
            e = exp_q.pop_front();
            check($sformatf("rdata_L%0d", L), rdata[g], e.rdata);
            check($sformatf("err_L%0d", L), {31'd0, errs[g]}, {31'd0, e.err});
          end
        end
        prev_v = vld[g];
      end
    end
  end

  // Hold rv[idx] until accepted; returns 2 time units after the accept edge
  task automatic wait_accept(input int idx);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[idx]) begin
        @(posedge clk); #2;
        return;
      end
    end
    fail("accept_timeout");
  endtask

  // Wait until every expected response has been consumed
  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) return;
    end
    fail("drain_timeout");
  endtask

  task automatic send(input int idx, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_e,
                      input bit push);
    if (push) exp_q.push_back('{rdata: exp_rd, err: exp_e});
    we = w; be = b; addr = a; wdata = d; pc = pc + 32'd4;
    rv[idx] = 1'b1;
    wait_accept(idx);
    rv[idx] = 1'b0;
  endtask

  task automatic xfer(input int idx, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_e);
    send(idx, w, b, a, d, exp_rd, exp_e, 1'b1);
    wait_drain();
  endtask

  // Stores with req_valid held high; acceptances must be LATENCY+1 apart
  task automatic burst(input int idx, input int n);
    b2b = 1'b1; we = 1'b1; be = 4'hF;
    rv[idx] = 1'b1;
    for (int k = 0; k < n; k++) begin
      addr  = 32'h100 + 32'(4 * k);
      wdata = 32'hA000_0000 + 32'(k);
      exp_q.push_back('{rdata: wdata, err: 1'b0});
      wait_accept(idx);
    end
    rv[idx] = 1'b0;
    wait_drain();
    b2b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, rdy[0]}, 32'd1);
    check("rst_resp_valid", {29'd0, vld}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_err", {31'd0, errs[0]}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Basic store/load, byte merge, zero-enable store, errors and bounds
    xfer(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 0);
    xfer(0, 0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    xfer(0, 1, 4'hF, 32'h20,   32'h11223344, 32'h11223344, 0);
    xfer(0, 1, 4'h5, 32'h20,   32'hAABBCCDD, 32'h11BB33DD, 0);
    xfer(0, 0, 4'hF, 32'h20,   32'h0,        32'h11BB33DD, 0);
    xfer(0, 1, 4'h0, 32'h24,   32'hFFFFFFFF, 32'h00000000, 0);
    xfer(0, 0, 4'h0, 32'h13,   32'h0,        32'h00000000, 1);
    xfer(0, 1, 4'hF, 32'h2FFC, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    xfer(0, 1, 4'hF, 32'h3000, 32'hFFFFFFFF, 32'h00000000, 1);
    xfer(0, 1, 4'hF, 32'h10000010, 32'h55555555, 32'h00000000, 1);
    xfer(0, 0, 4'h0, 32'h0,    32'h0,        32'h00000000, 0);
    xfer(0, 0, 4'h0, 32'h2FFC, 32'h0,        32'hCAFEF00D, 0);
    xfer(0, 0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    xfer(0, 0, 4'h0, 32'h24,   32'h0,        32'h00000000, 0);
    xfer(0, 0, 4'h0, 32'h2FFE, 32'h0,        32'h00000000, 1);

    // Response backpressure
    rr = 1'b0;
    send(0, 0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 0, 1'b1);
    hi = 0;
    for (int i = 0; i < 50 && hi == 0; i++) begin
      @(negedge clk);
      if (vld[0]) hi = 1;
    end
    if (hi == 0) fail("bp_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", {31'd0, vld[0]}, 32'd1);
      check("bp_rdata", rdata[0], 32'h11BB33DD);
      check("bp_err", {31'd0, errs[0]}, 32'd0);
      check("bp_req_ready", {31'd0, rdy[0]}, 32'd0);
    end
    @(posedge clk); #2;
    rr = 1'b1;
    wait_drain();
    check("bp_idle_req_ready", {31'd0, rdy[0]}, 32'd1);
    check("bp_idle_valid", {31'd0, vld[0]}, 32'd0);

    // Latency sweep and back-to-back issue on each instance
    burst(0, 3);
    xfer(1, 1, 4'hF, 32'h8, 32'h01020304, 32'h01020304, 0);
    xfer(1, 0, 4'h0, 32'h8, 32'h0,        32'h01020304, 0);
    burst(1, 3);
    xfer(2, 1, 4'hF, 32'h8, 32'h0BADF00D, 32'h0BADF00D, 0);
    xfer(2, 0, 4'h0, 32'h8, 32'h0,        32'h0BADF00D, 0);
    burst(2, 3);

    // Reset while the store waits: no response, no write, memory wiped
    send(0, 1, 4'hF, 32'h40, 32'h12345678, 32'h0, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #2;
    check("midrst_valid", {31'd0, vld[0]}, 32'd0);
    check("midrst_req_ready", {31'd0, rdy[0]}, 32'd1);
    check("midrst_rdata", rdata[0], 32'd0);
    check("midrst_err", {31'd0, errs[0]}, 32'd0);
    reset = 1'b0;
    acc_q.delete();
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld[0]) hi++;
    end
    check("midrst_no_resp", hi, 0);
    @(posedge clk); #2;
    xfer(0, 0, 4'h0, 32'h40, 32'h0, 32'h00000000, 0);
    xfer(0, 0, 4'h0, 32'h10, 32'h0, 32'h00000000, 0);
    xfer(1, 0, 4'h0, 32'h8,  32'h0, 32'h00000000, 0);

    check("exp_queue_empty", exp_q.size(), 0);
    check("acc_queue_empty", acc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the slave end of the core's load/store interface.
- Accepts one word-aligned request at a time through a valid/ready handshake.
- Performs the access after a fixed latency, then returns a response through a second valid/ready handshake.
- Replaces the zero-latency data memory when the core moves to stall-aware memory access.

Parameters:
DEPTH, 3072, number of 32-bit words stored; valid byte addresses are 0 to 4*DEPTH-1
LATENCY, 2, cycles from request acceptance edge to resp_valid high; legal range 1 to 15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_be  input  4  byte enables for stores; bit i selects byte lane [8i+7:8i]
req_addr  input  32  byte address
req_wdata  input  32  store data
req_pc  input  32  pc of the issuing instruction, used for trace only
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  32  load data; full word
resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE, counter 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - All DEPTH words cleared to 0.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE); it is a registered-state decode with no combinational path from req_valid.
  - IDLE: if req_valid, latch we/be/addr/wdata/pc.
    - LATENCY==1: go to RESP.
    - Otherwise: go to WAIT with counter=LATENCY-1.
  - WAIT: decrement counter each cycle; when the counter equals 1, the next state is RESP.
  - Entering RESP (same edge):
    - Error check: error when addr[1:0]!=0 or addr[31:2]>=DEPTH. On error: no memory change, resp_rdata=0, resp_err=1.
    - Otherwise, store: for each set bit of be, update that byte lane of mem[addr[31:2]]. resp_rdata = the word value after the write. resp_err=0.
    - Otherwise, load: resp_rdata = mem[addr[31:2]], resp_err=0.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1. On that edge go to IDLE and clear resp_valid.
  - Consequence: minimum issue interval is LATENCY+1 cycles. A new request is never accepted in the cycle a response is consumed.
- Latency: resp_valid rises exactly LATENCY cycles after the edge on which req_valid && req_ready was sampled.
- A store with be=4'b0000 is legal: memory is unchanged and a response is still returned.
- Request inputs are ignored outside IDLE. Latched values are used for the access, so inputs may change freely after acceptance.
- Reset mid-operation: reset in WAIT abandons the request, so no write occurs. Reset in RESP drops the pending response; the committed write is also wiped because memory clears.
- Address bits are never truncated silently. Any address at or beyond DEPTH words returns an error.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined:
  - On each successful store commit, print "@<pc>: *<byte addr> <= <new word>" with all values as 8-digit hex.
  - Errored requests print "@<pc>: DM error <addr>".
- Undefined: no display statements are compiled. Functional behaviour is identical either way.

Decomposition:
- Shared package mem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - WORD_W=32, BE_W=4
  - DM_DEPTH_DEFAULT=3072
- One natural sub-module, dm_byte_ram:
  - DEPTH-word array with per-lane write enable.
  - Synchronous write and synchronous clear on reset.
  - Combinational read.
- The FSM, counter and request latch stay in dm_responder.

Test Plan:
- Basic store then load, LATENCY=2:
  - Store addr=0x10, we=1, be=4'hF, wdata=0xDEADBEEF -> resp_valid 2 cycles after acceptance, resp_err=0.
  - Then load addr=0x10 -> resp_rdata=0xDEADBEEF.
- Byte-enable merge:
  - Preload 0x11223344 at 0x20, then store be=4'b0101 with wdata=0xAABBCCDD -> load returns 0x11BB33DD.
- Response backpressure:
  - Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata, resp_err stable and req_ready=0 throughout.
  - Raise resp_ready -> next cycle state IDLE, req_ready=1.
- Errors:
  - Load addr=0x13 -> resp_err=1, resp_rdata=0.
  - Store addr=4*3072 -> resp_err=1 and memory unchanged (verify by reading 0x0 and the last word, addr 0x2FFC).
- Reset mid-operation:
  - Accept store 0x40 <= 0x12345678, assert reset during WAIT -> resp_valid never rises, all outputs at reset values, subsequent load of 0x40 returns 0.
- LATENCY sweep:
  - LATENCY=1 and LATENCY=15 -> resp_valid rises exactly 1 and 15 cycles after acceptance.
  - Back-to-back req_valid held high -> acceptances spaced exactly LATENCY+1 cycles apart when resp_ready=1.
